// File: rtl/sd_cmd_transceiver.sv
// SPI-mode SD command engine: shifts out one 48-bit command frame on DI, then
// hunts for and captures an R1 (8-bit) or R3/R7 (40-bit) response from DO.
module sd_cmd_transceiver (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  index,
    input  logic [31:0] argument,
    input  logic        isStart,
    output logic        isBusy,
    output logic        isFinish,
    output logic        timeout,
    output logic [39:0] response,
    output logic        DI,
    input  logic        DO
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SEND = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_RECV = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]  state;
    logic [5:0]  cmd_idx;
    logic [31:0] cmd_arg;
    logic        long_rsp;
    logic [5:0]  bit_cnt;
    logic [6:0]  hi_cnt;
    logic [39:0] rx_sh;
    logic [6:0]  crc;
    logic [47:0] frame;

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb = c[6] ^ d[i];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    assign crc   = crc7({2'b01, cmd_idx, cmd_arg});
    assign frame = {2'b01, cmd_idx, cmd_arg, crc, 1'b1};

    assign isBusy   = (state == S_SEND) || (state == S_WAIT) || (state == S_RECV);
    assign isFinish = (state == S_DONE);
    // bit_cnt walks 47..0 during SEND, so the frame MSB leads
    assign DI       = (state == S_SEND) ? frame[bit_cnt] : 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            timeout  <= 1'b0;
            response <= 40'd0;
            cmd_idx  <= 6'd0;
            cmd_arg  <= 32'd0;
            long_rsp <= 1'b0;
            bit_cnt  <= 6'd0;
            hi_cnt   <= 7'd0;
            rx_sh    <= 40'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (isStart) begin
                        cmd_idx  <= index;
                        cmd_arg  <= argument;
                        long_rsp <= (index == 6'd8) || (index == 6'd58);
                        timeout  <= 1'b0;
                        bit_cnt  <= 6'd47;
                        state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (bit_cnt == 6'd0) begin
                        hi_cnt <= 7'd0;
                        state  <= S_WAIT;
                    end else begin
                        bit_cnt <= bit_cnt - 6'd1;
                    end
                end
                S_WAIT: begin
                    if (!DO) begin
                        // MSB is the 0 just seen; count the remaining bits
                        rx_sh   <= 40'd0;
                        bit_cnt <= long_rsp ? 6'd38 : 6'd6;
                        state   <= S_RECV;
                    end else if (hi_cnt == 7'd127) begin
                        response <= 40'hFF_FFFF_FFFF;
                        timeout  <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        hi_cnt <= hi_cnt + 7'd1;
                    end
                end
                S_RECV: begin
                    rx_sh <= {rx_sh[38:0], DO};
                    if (bit_cnt == 6'd0) begin
                        response <= {rx_sh[38:0], DO};
                        state    <= S_DONE;
                    end else begin
                        bit_cnt <= bit_cnt - 6'd1;
                    end
                end
                S_DONE: begin
                    if (!isStart) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_transceiver.sv
// Bench for sd_cmd_transceiver: vector table of commands with a response
// scoreboard, plus hand-written reset-abort and back-to-back sequences.
module tb_sd_cmd_transceiver;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  index;
    logic [31:0] argument;
    logic        isStart;
    logic        isBusy;
    logic        isFinish;
    logic        timeout;
    logic [39:0] response;
    logic        DI;
    logic        DO;

    int checks = 0;
    int errors = 0;
    bit overlap_seen = 1'b0;

    sd_cmd_transceiver dut (
        .clk(clk), .reset(reset), .index(index), .argument(argument),
        .isStart(isStart), .isBusy(isBusy), .isFinish(isFinish),
        .timeout(timeout), .response(response), .DI(DI), .DO(DO)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (isBusy && isFinish) overlap_seen = 1'b1;

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] arg;
        int          delay;     // high DO cycles before the response
        int          len;       // response bits driven; 0 = DO stuck high
        logic [39:0] rbits;     // bits driven, right-aligned, MSB first
        int          hold;      // extra DONE cycles with isStart still high
        bit          toggle;    // wiggle isStart during SEND
        logic [47:0] exp_frame;
        logic [39:0] exp_resp;
        logic        exp_to;
    } vec_t;

    typedef struct {
        logic [39:0] resp;
        logic        to;
        int          lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v);
        logic [47:0] cap;
        logic [39:0] prev;
        exp_t e, got;
        int cyc, k, lat;
        bit done;
        lat = (v.len == 0) ? 177 : 49 + v.delay + v.len;
        e.resp = v.exp_resp; e.to = v.exp_to; e.lat = lat;
        sb.push_back(e);
        @(negedge clk);
        index = v.idx; argument = v.arg; isStart = 1'b1;
        prev = response;
        cyc = 0;
        for (int i = 47; i >= 0; i--) begin
            @(negedge clk);
            cyc++;
            cap[i] = DI;
            if (i == 47) begin
                check("busy_at_A1", {63'd0, isBusy}, 64'd1);
                check("resp_held", {24'd0, response}, {24'd0, prev});
                index = ~v.idx; argument = ~v.arg;   // must not matter now
            end
            DO = 1'($urandom);                       // ignored during SEND
            if (v.toggle) isStart = i[0];
        end
        isStart = 1'b1;
        check("frame", {16'd0, cap}, {16'd0, v.exp_frame});
        done = 1'b0;
        k = 0;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cyc == 49) check("di_idle_wait", {63'd0, DI}, 64'd1);
            if (isFinish) begin
                done = 1'b1;
            end else begin
                if (v.len == 0 || k < v.delay || k >= v.delay + v.len) DO = 1'b1;
                else DO = v.rbits[v.len - 1 - (k - v.delay)];
                k++;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL finish_timeout: no isFinish within %0d cycles, expected %0d", cyc, lat);
        end else begin
            got = sb.pop_front();
            check("latency", 64'(cyc), 64'(got.lat));
            check("response", {24'd0, response}, {24'd0, got.resp});
            check("timeout", {63'd0, timeout}, {63'd0, got.to});
            check("busy_done", {63'd0, isBusy}, 64'd0);
        end
        DO = 1'b1;
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            check("finish_hold", {63'd0, isFinish}, 64'd1);
        end
        isStart = 1'b0;
        @(negedge clk);
        check("finish_clear", {63'd0, isFinish}, 64'd0);
    endtask

    initial begin
        vecs[0] = '{6'd0,  32'h0000_0000, 3, 8,  40'h01, 0, 1'b0,
                    48'h40_0000_0000_95, 40'h00_0000_0001, 1'b0};
        vecs[1] = '{6'd8,  32'h0000_01AA, 0, 40, 40'h01_0000_01AA, 4, 1'b0,
                    48'h48_0000_01AA_87, 40'h01_0000_01AA, 1'b0};
        vecs[2] = '{6'd17, 32'h0000_0000, 0, 0,  40'h0, 0, 1'b0,
                    48'h51_0000_0000_55, 40'hFF_FFFF_FFFF, 1'b1};
        vecs[3] = '{6'd58, 32'h0000_0000, 8, 40, 40'h00_C0FF_8000, 0, 1'b1,
                    48'h7A_0000_0000_FD, 40'h00_C0FF_8000, 1'b0};

        reset = 1'b1; isStart = 1'b0; index = 6'd0; argument = 32'd0; DO = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_di", {63'd0, DI}, 64'd1);
        check("rst_busy", {63'd0, isBusy}, 64'd0);
        check("rst_finish", {63'd0, isFinish}, 64'd0);
        check("rst_timeout", {63'd0, timeout}, 64'd0);
        check("rst_response", {24'd0, response}, 64'd0);

        for (int i = 0; i < 4; i++) run(vecs[i]);

        // reset while the frame is going out
        @(negedge clk);
        index = 6'd0; argument = 32'd0; isStart = 1'b1;
        repeat (10) @(negedge clk);
        check("mid_send_busy", {63'd0, isBusy}, 64'd1);
        reset = 1'b1; isStart = 1'b0;
        @(negedge clk);
        check("abort_di", {63'd0, DI}, 64'd1);
        check("abort_busy", {63'd0, isBusy}, 64'd0);
        check("abort_response", {24'd0, response}, 64'd0);
        reset = 1'b0;
        run(vecs[0]);

        // back-to-back CMD55 / CMD41
        run('{6'd55, 32'h0000_0000, 0, 8, 40'h01, 0, 1'b0,
              48'h77_0000_0000_65, 40'h00_0000_0001, 1'b0});
        run('{6'd41, 32'h4000_0000, 1, 8, 40'h00, 0, 1'b0,
              48'h69_4000_0000_77, 40'h00_0000_0000, 1'b0});

        check("busy_finish_overlap", {63'd0, overlap_seen}, 64'd0);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sd_cmd_transceiver.md
# sd_cmd_transceiver

SPI-mode SD card command/response engine. It serialises one 48-bit SD command frame (start bits, index, argument, CRC7, end bit) onto the card's data-in line. It then hunts for and captures the card's R1 (8-bit) or R3/R7 (40-bit) response from the card's data-out line. It sits between the SD initialisation/read controller and the SPI pins, and runs one bit per `clk` cycle; SCK generation is external and is derived from `clk`.

## Interface
- No parameters.
- `clk` input 1 — system clock; all logic on the rising edge.
- `reset` input 1 — synchronous, active-high reset.
- `index` input 6 — command index (CMD0..CMD63). Sampled when a command is accepted.
- `argument` input 32 — command argument. Sampled when a command is accepted.
- `isStart` input 1 — level request. A command is accepted when it is high in IDLE.
- `isBusy` output 1 — high from acceptance until completion.
- `isFinish` output 1 — completion flag. Held until `isStart` is dropped.
- `timeout` output 1 — valid while `isFinish` = 1; 1 = no response detected.
- `response` output 40 — captured response, right-aligned.
- `DI` output 1 — serial command to the card (MOSI). Idles high.
- `DO` input 1 — serial response from the card (MISO).

## Operation
- Reset: state IDLE; `isBusy`=0, `isFinish`=0, `timeout`=0, `DI`=1, `response`=0. Reset in any state aborts the operation immediately; nothing is partially updated afterwards.
- Frame, MSB first, 48 bits: `0`, `1`, `index[5:0]`, `argument[31:0]`, `crc7[6:0]`, `1`.
- CRC7: polynomial x^7+x^3+1, initial value 0, computed over the first 40 frame bits. It is computed from the latched index and argument.
- Response length is latched at acceptance:
  - 40 bits when `index` = 8 or 58.
  - 8 bits for every other index.
- States:
  - IDLE: `isBusy`=0, `isFinish`=0, `DI`=1. If `isStart`=1, latch `index` and `argument`, set `isBusy`=1, clear `timeout`, go to SEND.
  - SEND: drive frame bits 47 down to 0 on `DI`, one per cycle. After bit 0, `DI` returns to 1 and the state goes to WAIT.
  - WAIT: sample `DO` each cycle.
    - The first sample equal to 0 is the response MSB; it is shifted in and the state goes to RECV.
    - After 128 consecutive samples of 1: set `response`=40'hFF_FFFF_FFFF and `timeout`=1, then go to DONE.
  - RECV: shift in the remaining 7 or 39 bits, MSB first. On the last bit, load `response`, then go to DONE.
    - 8-bit: R1 occupies [7:0]; [39:8] are zero.
    - 40-bit: R1 occupies [39:32].
  - DONE: `isBusy`=0, `isFinish`=1. Remain while `isStart`=1; go to IDLE when `isStart`=0.
- `isStart` is ignored while busy. `index` and `argument` changes after acceptance have no effect.
- `response` changes only on completion or reset; the previous value is held during a new command.
- `DO` is ignored outside WAIT and RECV.

## Timing
- Let cycle A be the edge where IDLE sees `isStart`=1.
  - `isBusy` is 1 from A+1.
  - `DI` carries frame bit 47 in cycle A+1 and bit 0 in cycle A+48.
  - From A+49, `DI`=1 and WAIT samples `DO` on each edge.
- If the response MSB is sampled at edge R:
  - The 8-bit last bit is sampled at R+7; 40-bit at R+39.
  - `response`, `isFinish`=1 and `isBusy`=0 are all visible the cycle after the last bit.
- Minimum command-to-finish for R1 with an immediate response: 57 cycles after A.
- The timeout fires after the 128th high sample; `isFinish` rises the next cycle.
- `isFinish` falls the cycle after `isStart` is sampled low in DONE. A new command can be accepted one cycle later.
- `isBusy` and `isFinish` are never 1 simultaneously.

## Test plan
- CMD0, arg 0, `DO` held high for 3 cycles after the frame then 8'h01 -> `DI` stream is 40 00 00 00 00 95; `response`=40'h00_0000_0001, `timeout`=0.
- CMD8, arg 32'h0000_01AA, response 40'h01_0000_01AA -> frame 48 00 00 01 AA 87; captures all 40 bits; `isFinish` is held until `isStart` falls, then clears one cycle later.
- CMD17 with `DO` stuck high -> after 128 WAIT cycles, `response`=40'hFF_FFFF_FFFF and `timeout`=1.
- CMD58 with response 40'h00_C0FF_8000 and 8 high cycles of delay -> `response` matches exactly; toggle `isStart` during SEND -> no effect.
- Assert `reset` mid-SEND -> next cycle `DI`=1, `isBusy`=0, `response` unchanged-from-reset value 0; a fresh CMD0 afterwards completes normally.
- Back-to-back: CMD55 (R1 8'h01) then CMD41 arg 32'h4000_0000 (R1 8'h00) -> each frame carries the correct CRC; responses are 8'h01 then 8'h00.
